simple_dma_rd: RTL and testbench

Read-direction companion to the SDRAM write DMA: queues (start address, length) commands, issues pipelined Avalon-MM burst-free reads of 128-bit words to SDRAM and streams the returned data out over a valid/ready interface. It sits between the SDRAM controller read port and a downstream consumer, such as a line-output or USB/host path. Flow control is credit-based, so `SDRAM_READDATAVALID` never has to be stalled.

---
 rtl/simple_dma_rd_if.sv | 33 +++
 rtl/simple_dma_rd.sv | 175 +++++++++++++++++
 tb/tb_simple_dma_rd.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_dma_rd_if.sv
// Command, SDRAM read-port and output-stream signals of the read DMA.
// master = DMA side, slave = environment (SDRAM controller, host, consumer).
interface simple_dma_rd_if;
   logic [27:0]  START_ADR;
   logic [27:0]  BUF_SIZE;
   logic         START;
   logic [15:0]  DONE_CNT;
   logic         CMD_FIFO_EMPTY;
   logic         CMD_OVF;
   logic         BUSY;
   logic [27:0]  SDRAM_ADDRESS;
   logic         SDRAM_READ;
   logic         SDRAM_WAITREQUEST;
   logic [127:0] SDRAM_READDATA;
   logic         SDRAM_READDATAVALID;
   logic [127:0] OUT_DATA;
   logic         OUT_VALID;
   logic         OUT_READY;

   modport master (
      input  START_ADR, BUF_SIZE, START, SDRAM_WAITREQUEST, SDRAM_READDATA,
             SDRAM_READDATAVALID, OUT_READY,
      output DONE_CNT, CMD_FIFO_EMPTY, CMD_OVF, BUSY, SDRAM_ADDRESS, SDRAM_READ,
             OUT_DATA, OUT_VALID
   );

   modport slave (
      output START_ADR, BUF_SIZE, START, SDRAM_WAITREQUEST, SDRAM_READDATA,
             SDRAM_READDATAVALID, OUT_READY,
      input  DONE_CNT, CMD_FIFO_EMPTY, CMD_OVF, BUSY, SDRAM_ADDRESS, SDRAM_READ,
             OUT_DATA, OUT_VALID
   );
endinterface

// File: rtl/simple_dma_rd.sv
// Queued SDRAM read DMA: START edge to first read in 3 cycles, read data to OUT_VALID in 1.
// Reads are only raised while reserved (outstanding + buffered) words < 2**BUF_DEPTH, so read data is never stalled.
module simple_dma_rd #(
   parameter int CMD_DEPTH = 2,
   parameter int BUF_DEPTH = 4
) (
   input  logic            CLK,
   input  logic            RST,
   simple_dma_rd_if.master bus
);
   localparam int CN = 2**CMD_DEPTH;
   localparam int BN = 2**BUF_DEPTH;
   localparam logic [BUF_DEPTH:0] RSV_MAX = {1'b1, {BUF_DEPTH{1'b0}}};
   localparam logic [BUF_DEPTH:0] ONE_B   = {{BUF_DEPTH{1'b0}}, 1'b1};
   localparam logic [CMD_DEPTH:0] ONE_C   = {{CMD_DEPTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;

   state_t         state;
   logic           rd_q;
   logic [27:0]    addr_q;
   logic [27:0]    issue_cnt;
   logic [27:0]    rx_cnt;
   logic [15:0]    done_q;

   // ---------------- command queue ----------------
   logic [55:0]        cmd_mem [CN];
   logic [CMD_DEPTH:0] cwp, crp;
   logic               start_d, ovf_q;
   logic               start_edge, cmd_empty, cmd_full, cmd_push, cmd_pop;
   logic [55:0]        cmd_head;

   assign start_edge = bus.START & ~start_d;
   assign cmd_empty  = (cwp == crp);
   assign cmd_full   = (cwp[CMD_DEPTH] != crp[CMD_DEPTH]) &&
                       (cwp[CMD_DEPTH-1:0] == crp[CMD_DEPTH-1:0]);
   assign cmd_push   = start_edge & ~cmd_full;
   assign cmd_pop    = (state == IDLE) & ~cmd_empty;
   assign cmd_head   = cmd_mem[crp[CMD_DEPTH-1:0]];

   always_ff @(posedge CLK) begin
      if (cmd_push) cmd_mem[cwp[CMD_DEPTH-1:0]] <= {bus.BUF_SIZE, bus.START_ADR};
   end

   // full is judged before this cycle's pop, so a simultaneous pop does not rescue the edge
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         start_d <= 1'b0;
         cwp     <= '0;
         crp     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         start_d <= bus.START;
         if (cmd_push) cwp <= cwp + ONE_C;
         if (cmd_pop)  crp <= crp + ONE_C;
         if (start_edge & cmd_full) ovf_q <= 1'b1;
      end
   end

   // ---------------- credit and output buffer ----------------
   logic               accept, pop, ret, credit;
   logic [BUF_DEPTH:0] rsv, rsv_nxt, outs;
   logic [127:0]       buf_mem [BN];
   logic [BUF_DEPTH:0] bwp, brp;
   logic               buf_empty, head_free, bypass, buf_wr, buf_rd;
   logic               vld_q;
   logic [127:0]       dat_q;

   assign accept    = rd_q & ~bus.SDRAM_WAITREQUEST;
   assign pop       = vld_q & bus.OUT_READY;
   assign ret       = bus.SDRAM_READDATAVALID & (outs != '0);
   assign buf_empty = (bwp == brp);
   assign head_free = ~vld_q | pop;
   assign bypass    = ret & buf_empty & head_free;
   assign buf_wr    = ret & ~bypass;
   assign buf_rd    = head_free & ~buf_empty;

   always_comb begin
      rsv_nxt = rsv;
      if (accept & ~pop)      rsv_nxt = rsv + ONE_B;
      else if (pop & ~accept) rsv_nxt = rsv - ONE_B;
   end
   assign credit = (rsv_nxt < RSV_MAX);

   always_ff @(posedge CLK) begin
      if (buf_wr) buf_mem[bwp[BUF_DEPTH-1:0]] <= bus.SDRAM_READDATA;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rsv   <= '0;
         outs  <= '0;
         bwp   <= '0;
         brp   <= '0;
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         rsv <= rsv_nxt;
         if (accept & ~ret)      outs <= outs + ONE_B;
         else if (ret & ~accept) outs <= outs - ONE_B;
         if (buf_wr) bwp <= bwp + ONE_B;
         if (buf_rd) brp <= brp + ONE_B;
         if (head_free) begin
            if (!buf_empty) begin
               dat_q <= buf_mem[brp[BUF_DEPTH-1:0]];
               vld_q <= 1'b1;
            end else if (ret) begin
               dat_q <= bus.SDRAM_READDATA;
               vld_q <= 1'b1;
            end else begin
               vld_q <= 1'b0;
            end
         end
      end
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         rd_q      <= 1'b0;
         addr_q    <= '0;
         issue_cnt <= '0;
         rx_cnt    <= '0;
         done_q    <= '0;
      end else begin
         case (state)
            IDLE: if (!cmd_empty) begin
               addr_q    <= cmd_head[27:0];
               issue_cnt <= cmd_head[55:28];
               rx_cnt    <= cmd_head[55:28];
               state     <= LOAD;
            end
            LOAD: if (rx_cnt == 28'd0) begin
               done_q <= done_q + 16'd1;
               state  <= IDLE;
            end else begin
               rd_q  <= credit;
               state <= ISSUE;
            end
            ISSUE: begin
               if (accept) begin
                  addr_q    <= addr_q + 28'd1;
                  issue_cnt <= issue_cnt - 28'd1;
                  if (issue_cnt == 28'd1) begin
                     rd_q  <= 1'b0;
                     state <= DRAIN;
                  end else begin
                     rd_q <= credit;
                  end
               end else if (!rd_q) begin
                  rd_q <= credit;
               end
               if (pop) rx_cnt <= rx_cnt - 28'd1;
            end
            DRAIN: if (rx_cnt == 28'd0) begin
               state <= IDLE;
            end else if (pop) begin
               rx_cnt <= rx_cnt - 28'd1;
               if (rx_cnt == 28'd1) done_q <= done_q + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.DONE_CNT       = done_q;
   assign bus.CMD_FIFO_EMPTY = cmd_empty;
   assign bus.CMD_OVF        = ovf_q;
   assign bus.BUSY           = (state != IDLE);
   assign bus.SDRAM_ADDRESS  = addr_q;
   assign bus.SDRAM_READ     = rd_q;
   assign bus.OUT_DATA       = dat_q;
   assign bus.OUT_VALID      = vld_q;
endmodule

// File: tb/tb_simple_dma_rd.sv
// Bench for simple_dma_rd: SDRAM memory model with in-order variable latency, random stalls,
// and a command-level reference model that predicts every read address and output word.
module tb_simple_dma_rd;
   logic CLK = 1'b0;
   logic RST = 1'b0;

   simple_dma_rd_if bus();

   simple_dma_rd #(.CMD_DEPTH(2), .BUF_DEPTH(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // environment knobs
   int lat_min = 5, lat_max = 5, wr_pct = 0, rdy_pct = 100;

   // reference model state
   logic [27:0]  exp_addr [$];
   logic [127:0] exp_data [$];
   int           model_q   = 0;
   bit           model_ovf = 1'b0;
   int           exp_done  = 0;
   int           accepts = 0, pops = 0, last_pop_cyc = 0, done_cyc = 0;

   // SDRAM response pipeline
   int           resp_due [$];
   logic [127:0] resp_dat [$];
   int           last_due = 0;

   function automatic logic [127:0] pat(input logic [27:0] a);
      return {4'hA, a, 4'h5, ~a, 4'h3, a ^ 28'h5A5A5A5, 4'hC, a + 28'h0000123};
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_read"},  128'(bus.SDRAM_READ),     128'(0));
      chk({tag, "_adr"},   128'(bus.SDRAM_ADDRESS),  128'(0));
      chk({tag, "_ovld"},  128'(bus.OUT_VALID),      128'(0));
      chk({tag, "_odat"},  bus.OUT_DATA,             128'(0));
      chk({tag, "_done"},  128'(bus.DONE_CNT),       128'(0));
      chk({tag, "_empty"}, 128'(bus.CMD_FIFO_EMPTY), 128'(1));
      chk({tag, "_ovf"},   128'(bus.CMD_OVF),        128'(0));
      chk({tag, "_busy"},  128'(bus.BUSY),           128'(0));
   endtask

   // command-level model: 4-entry queue, each accepted command yields size words at adr+i mod 2^28
   task automatic model_start(input logic [27:0] adr, input logic [27:0] size);
      if (model_q == 4) begin
         model_ovf = 1'b1;
      end else begin
         model_q++;
         exp_done++;
         for (int i = 0; i < int'(size); i++) begin
            logic [27:0] a;
            a = adr + 28'(i);
            exp_addr.push_back(a);
            exp_data.push_back(pat(a));
         end
      end
   endtask

   task automatic queue_cmd(input logic [27:0] adr, input logic [27:0] size);
      @(posedge CLK); #1;
      bus.START_ADR = adr;
      bus.BUF_SIZE  = size;
      bus.START     = 1'b1;
      model_start(adr, size);
      @(posedge CLK); #1;
      bus.START     = 1'b0;
      bus.START_ADR = 28'($urandom);
      bus.BUF_SIZE  = 28'($urandom);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!(bus.DONE_CNT == 16'(exp_done) && !bus.BUSY) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      chk(tag, 128'(bus.DONE_CNT), 128'(16'(exp_done)));
      chk({tag, "_idle"}, 128'(bus.BUSY), 128'(0));
      model_q = 0;
   endtask

   // environment driver: stalls, consumer readiness, returned read data
   initial begin
      bus.SDRAM_WAITREQUEST   = 1'b0;
      bus.OUT_READY           = 1'b1;
      bus.SDRAM_READDATAVALID = 1'b0;
      bus.SDRAM_READDATA      = '0;
      forever begin
         @(posedge CLK); #1;
         bus.SDRAM_WAITREQUEST = (int'($urandom_range(99)) < wr_pct);
         bus.OUT_READY         = (int'($urandom_range(99)) < rdy_pct);
         if (resp_due.size() != 0 && resp_due[0] <= cyc) begin
            bus.SDRAM_READDATAVALID = 1'b1;
            bus.SDRAM_READDATA      = resp_dat.pop_front();
            void'(resp_due.pop_front());
         end else begin
            bus.SDRAM_READDATAVALID = 1'b0;
            bus.SDRAM_READDATA      = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   // monitor: Avalon hold rule, read addresses, output stream, DONE_CNT change time
   initial begin
      bit          prev_stall;
      logic [27:0] prev_adr;
      logic [15:0] prev_done;
      int          due;
      prev_stall = 1'b0;
      prev_adr   = '0;
      prev_done  = '0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            prev_stall = 1'b0;
            prev_done  = '0;
         end else begin
            if (prev_stall) begin
               chk("hold_read", 128'(bus.SDRAM_READ), 128'(1));
               chk("hold_adr", 128'(bus.SDRAM_ADDRESS), 128'(prev_adr));
            end
            if (bus.SDRAM_READ && !bus.SDRAM_WAITREQUEST) begin
               accepts++;
               chk("rd_pending", 128'(exp_addr.size() != 0), 128'(1));
               if (exp_addr.size() != 0)
                  chk("rd_adr", 128'(bus.SDRAM_ADDRESS), 128'(exp_addr.pop_front()));
               due = cyc + int'($urandom_range(lat_max, lat_min));
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               resp_due.push_back(due);
               resp_dat.push_back(pat(bus.SDRAM_ADDRESS));
            end
            prev_stall = bus.SDRAM_READ && bus.SDRAM_WAITREQUEST;
            prev_adr   = bus.SDRAM_ADDRESS;
            if (bus.OUT_VALID && bus.OUT_READY) begin
               pops++;
               last_pop_cyc = cyc;
               chk("pop_pending", 128'(exp_data.size() != 0), 128'(1));
               if (exp_data.size() != 0) chk("pop_dat", bus.OUT_DATA, exp_data.pop_front());
            end
            if (bus.DONE_CNT != prev_done) done_cyc = cyc;
            prev_done = bus.DONE_CNT;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0, p0, n;
      bus.START     = 1'b0;
      bus.START_ADR = '0;
      bus.BUF_SIZE  = '0;
      #1 RST = 1'b1;
      #2 chk_reset("rst0");
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      // single command with handshake timing
      @(posedge CLK); #1;
      bus.START_ADR = 28'h100;
      bus.BUF_SIZE  = 28'd8;
      bus.START     = 1'b1;
      model_start(28'h100, 28'd8);
      a0 = accepts; p0 = pops;
      @(negedge CLK); chk("t_empty_n0", 128'(bus.CMD_FIFO_EMPTY), 128'(1));
      @(posedge CLK); #1 bus.START = 1'b0;
      @(negedge CLK); chk("t_empty_n1", 128'(bus.CMD_FIFO_EMPTY), 128'(0));
                      chk("t_busy_n1", 128'(bus.BUSY), 128'(0));
      @(negedge CLK); chk("t_busy_n2", 128'(bus.BUSY), 128'(1));
                      chk("t_read_n2", 128'(bus.SDRAM_READ), 128'(0));
      @(negedge CLK); chk("t_read_n3", 128'(bus.SDRAM_READ), 128'(1));
      wait_done("t1_done", 200);
      chk("t1_reads", 128'(accepts - a0), 128'(8));
      chk("t1_pops", 128'(pops - p0), 128'(8));
      chk("t1_done_lat", 128'(done_cyc), 128'(last_pop_cyc + 1));
      chk("t1_busy_lat", 128'(cyc), 128'(done_cyc + 1));

      // consumer stalled: credit must cap reads at 16
      rdy_pct = 0;
      a0 = accepts; p0 = pops;
      queue_cmd(28'h4000, 28'd40);
      repeat (60) @(negedge CLK);
      chk("t2_reads_capped", 128'(accepts - a0), 128'(16));
      chk("t2_read_low", 128'(bus.SDRAM_READ), 128'(0));
      rdy_pct = 100;
      wait_done("t2_done", 400);
      chk("t2_reads", 128'(accepts - a0), 128'(40));
      chk("t2_pops", 128'(pops - p0), 128'(40));

      // random stalls, latency and consumer readiness
      wr_pct = 50; rdy_pct = 70; lat_min = 1; lat_max = 6;
      for (int k = 0; k < 4; k++) begin
         queue_cmd(28'($urandom), 28'($urandom_range(24, 1)));
         wait_done("t3_done", 800);
      end
      chk("t3_drained", 128'(exp_data.size()), 128'(0));
      wr_pct = 0; rdy_pct = 100; lat_min = 5; lat_max = 5;

      // address wrap at 2^28
      p0 = pops;
      queue_cmd(28'hFFFFFFE, 28'd4);
      wait_done("t4_done", 200);
      chk("t4_pops", 128'(pops - p0), 128'(4));

      // queue overflow while a blocker command is stuck in DRAIN
      rdy_pct = 0;
      queue_cmd(28'h300, 28'd1);
      n = 0;
      while (!bus.BUSY && n < 10) begin @(negedge CLK); n++; end
      chk("t5_blk_busy", 128'(bus.BUSY), 128'(1));
      model_q = 0;
      a0 = accepts;
      queue_cmd(28'h500, 28'd1);
      queue_cmd(28'h600, 28'd0);
      queue_cmd(28'h700, 28'd3);
      queue_cmd(28'h800, 28'd2);
      @(negedge CLK); chk("t5_ovf_pre", 128'(bus.CMD_OVF), 128'(model_ovf));
      queue_cmd(28'h900, 28'd4);
      @(negedge CLK); chk("t5_ovf_set", 128'(bus.CMD_OVF), 128'(model_ovf));
      chk("t5_ovf_model", 128'(model_ovf), 128'(bus.CMD_FIFO_EMPTY == 1'b0));
      rdy_pct = 100;
      wait_done("t5_done", 400);
      repeat (30) @(negedge CLK);
      chk("t5_no_extra", 128'(bus.DONE_CNT), 128'(16'(exp_done)));
      chk("t5_reads", 128'(accepts - a0), 128'(1 + 0 + 3 + 2 + 1));
      chk("t5_adr_left", 128'(exp_addr.size()), 128'(0));

      // reset mid-ISSUE with 3 reads outstanding
      lat_min = 8; lat_max = 8;
      a0 = accepts;
      queue_cmd(28'h2000, 28'd10);
      n = 0;
      while (accepts - a0 < 3 && n < 40) begin @(negedge CLK); n++; end
      chk("t6_three_out", 128'(accepts - a0), 128'(3));
      @(posedge CLK); #2 RST = 1'b1;
      #1 chk_reset("rst_mid");
      exp_addr.delete();
      exp_data.delete();
      model_q = 0; model_ovf = 1'b0; exp_done = 0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         chk("t6_late_ignored", 128'(bus.OUT_VALID), 128'(0));
      end
      lat_min = 3; lat_max = 3;
      p0 = pops;
      queue_cmd(28'h3000, 28'd3);
      wait_done("t6_done", 200);
      chk("t6_pops", 128'(pops - p0), 128'(3));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
